// File: rtl/ch_fifo_pkg.sv
// Shared constants for the compression-channel FIFOs: 64 data bits plus a
// "last" tag bit per entry.
package ch_fifo_pkg;

   localparam int CH_FIFO_DATA_WIDTH = 65;
   localparam int CH_FIFO_ADDR_WIDTH = 9;
   localparam int CH_FIFO_DEPTH      = 2 ** CH_FIFO_ADDR_WIDTH;
   localparam int CH_LAST_BIT        = 64;

endpackage : ch_fifo_pkg

// File: rtl/ch_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are never reset; the owner tracks which entries are valid.
module ch_fifo_ram #(
   parameter int DATA_WIDTH = 65,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  wb_clk_i,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge wb_clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : ch_fifo_ram

// File: rtl/ch_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for the compression channel data
// paths, with occupancy and threshold status for producer/consumer throttling.
module ch_sync_fifo
   import ch_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = CH_FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = CH_FIFO_ADDR_WIDTH
) (
   input  logic                  wb_clk_i,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] prog_full_thresh,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  prog_full,
   output logic [ADDR_WIDTH:0]   rd_data_count,
   output logic [ADDR_WIDTH:0]   wr_data_count
);

   localparam int                DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_FULL  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_AFULL = (ADDR_WIDTH + 1)'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic                  we;
   logic                  re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Handshake: a write is accepted on any edge where wr_en is high and full
   // was low before the edge; a read pops the head on any edge where rd_en is
   // high and empty was low. Requests that are not accepted are dropped.
   assign we = wr_en & ~full;
   assign re = rd_en & ~empty;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (we) begin
            wptr <= wptr + 1'b1;
         end
         if (re) begin
            rptr <= rptr + 1'b1;
         end
         case ({we, re})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   ch_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .wb_clk_i (wb_clk_i),
      .we       (we),
      .waddr    (wptr),
      .wdata    (din),
      .raddr    (rptr),
      .rdata    (ram_rdata)
   );

   // Flags decode the registered count only, so they never see din or wr_en.
   assign empty         = (cnt == '0);
   assign almost_empty  = (cnt <= (ADDR_WIDTH + 1)'(1));
   assign full          = (cnt == CNT_FULL);
   assign almost_full   = (cnt >= CNT_AFULL);
   assign prog_full     = (prog_full_thresh != '0) && (cnt >= {1'b0, prog_full_thresh});
   assign rd_data_count = cnt;
   assign wr_data_count = cnt;

   // Stale RAM contents stay hidden while the FIFO holds nothing.
   assign dout = empty ? '0 : ram_rdata;

endmodule : ch_sync_fifo

// File: tb/tb_ch_sync_fifo.sv
// Directed bench for ch_sync_fifo: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted read.
module tb_ch_sync_fifo;

   localparam int DW    = 65;
   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic          wb_clk_i = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] prog_full_thresh;
   logic [DW-1:0] dout;
   logic          empty;
   logic          almost_empty;
   logic          full;
   logic          almost_full;
   logic          prog_full;
   logic [AW:0]   rd_data_count;
   logic [AW:0]   wr_data_count;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mon_exp;
   int            checks = 0;
   int            errors = 0;
   int            mcnt   = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   ch_sync_fifo dut (
      .wb_clk_i         (wb_clk_i),
      .rst_n            (rst_n),
      .din              (din),
      .wr_en            (wr_en),
      .rd_en            (rd_en),
      .prog_full_thresh (prog_full_thresh),
      .dout             (dout),
      .empty            (empty),
      .almost_empty     (almost_empty),
      .full             (full),
      .almost_full      (almost_full),
      .prog_full        (prog_full),
      .rd_data_count    (rd_data_count),
      .wr_data_count    (wr_data_count)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Status against an independently known occupancy value.
   task automatic check_status(input string tag, input int exp_cnt);
      logic pf_exp;
      pf_exp = (prog_full_thresh != '0) && (exp_cnt >= int'(prog_full_thresh));
      chk({tag, " rd_data_count"}, DW'(rd_data_count), DW'(exp_cnt));
      chk({tag, " wr_data_count"}, DW'(wr_data_count), DW'(exp_cnt));
      chk({tag, " empty"},         DW'(empty),         DW'(exp_cnt == 0));
      chk({tag, " almost_empty"},  DW'(almost_empty),  DW'(exp_cnt <= 1));
      chk({tag, " full"},          DW'(full),          DW'(exp_cnt == DEPTH));
      chk({tag, " almost_full"},   DW'(almost_full),   DW'(exp_cnt >= DEPTH - 1));
      chk({tag, " prog_full"},     DW'(prog_full),     DW'(pf_exp));
      if (exp_cnt == 0) begin
         chk({tag, " dout when empty"}, dout, '0);
      end
   endtask

   function automatic logic [DW-1:0] word(input int i);
      logic [31:0] hi;
      logic [31:0] lo;
      hi = 32'hC0DE_0000 | 32'(i);
      lo = 32'(i * 3 + 1);
      return {i[0], hi, lo};
   endfunction

   // One clock of stimulus; the expected queue follows a reference occupancy.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      logic we_m;
      logic re_m;
      wr_en = w;
      rd_en = r;
      din   = d;
      we_m  = w && (mcnt < DEPTH);
      re_m  = r && (mcnt > 0);
      if (we_m) exp_q.push_back(d);
      mcnt = mcnt + int'(we_m) - int'(re_m);
      @(posedge wb_clk_i);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   always @(negedge wb_clk_i) begin
      if (rst_n && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read data actual=%h required=<no entry expected>", dout);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("read data", dout, mon_exp);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b0;
      din              = '0;
      wr_en            = 1'b0;
      rd_en            = 1'b0;
      prog_full_thresh = '0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      check_status("in reset", 0);
      rst_n = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_status("idle", 0);

      // Single word: FWFT latency of one cycle, then pop back to empty.
      step(1'b1, 1'b0, 65'h1_0000_0000_0000_00AA);
      chk("single dout", dout, 65'h1_0000_0000_0000_00AA);
      check_status("single", 1);
      step(1'b0, 1'b1, '0);
      check_status("single read", 0);

      // Fill to full with threshold 256, then one dropped overflow write.
      prog_full_thresh = 9'h100;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, word(i));
         check_status("fill", i + 1);
         if (i + 1 == 255) chk("prog_full below thresh", DW'(prog_full), '0);
         if (i + 1 == 256) chk("prog_full at thresh", DW'(prog_full), 1);
         if (i + 1 == 511) chk("almost_full at 511", DW'(almost_full), 1);
         if (i + 1 == 512) chk("full at 512", DW'(full), 1);
      end
      step(1'b1, 1'b0, 65'h0_DEAD_BEEF_DEAD_BEEF);
      check_status("overflow", 512);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, '0);
         check_status("drain", DEPTH - 1 - i);
      end

      // Simultaneous read and write at occupancy 5.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, word(100 + i));
      check_status("five", 5);
      step(1'b1, 1'b1, word(105));
      check_status("rw at five", 5);
      chk("rw at five dout", dout, word(101));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
      check_status("five drained", 0);

      // Simultaneous read and write while empty: only the write lands.
      step(1'b1, 1'b1, word(200));
      check_status("rw empty", 1);
      chk("rw empty dout", dout, word(200));
      step(1'b0, 1'b1, '0);
      check_status("rw empty drained", 0);

      // Simultaneous read and write while full: only the read lands.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, word(1000 + i));
      check_status("refill", 512);
      step(1'b1, 1'b1, word(9999));
      check_status("rw full", 511);
      chk("rw full dout", dout, word(1001));
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0);
      check_status("rw full drained", 0);

      // Stream through the pointer wrap at constant occupancy 3.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, word(3000 + i));
      for (int i = 0; i < 600; i++) begin
         step(1'b1, 1'b1, word(3003 + i));
         if (i % 50 == 0) check_status("wrap", 3);
      end
      check_status("wrap end", 3);
      chk("wrap head", dout, word(3600));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
      check_status("wrap drained", 0);

      // Asynchronous reset with 10 entries stored, away from any clock edge.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, word(5000 + i));
      check_status("before reset", 10);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      mcnt = 0;
      check_status("async reset", 0);
      #1;
      rst_n = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_status("after reset", 0);
      step(1'b1, 1'b0, 65'h0_1234_5678_9ABC_DEF0);
      chk("post reset dout", dout, 65'h0_1234_5678_9ABC_DEF0);
      check_status("post reset write", 1);
      step(1'b0, 1'b1, '0);
      check_status("post reset read", 0);

      chk("scoreboard leftover", DW'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ch_sync_fifo

// File: doc/ch_sync_fifo.md
Name: ch_sync_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO, 65 bits wide and 512 deep.
- Used by the compression channel for its source and destination data paths. Each entry is 64 data bits plus one "last" tag bit.
- Provides full, almost, programmable-full and occupancy status so producers and consumers can throttle without extra handshake logic.

Parameters:
- DATA_WIDTH, 65: entry width in bits.
- ADDR_WIDTH, 9: pointer width. DEPTH = 2**ADDR_WIDTH = 512 entries.

Ports:
- wb_clk_i, in, 1: the single clock. All logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset. Clears pointers, count and flags.
- din, in, DATA_WIDTH: write data.
- wr_en, in, 1: write request.
- rd_en, in, 1: read request. Pops the head entry.
- prog_full_thresh, in, ADDR_WIDTH: programmable-full threshold. Quasi-static.
- dout, out, DATA_WIDTH: head entry (FWFT).
- empty, out, 1: FIFO holds 0 entries.
- almost_empty, out, 1: FIFO holds 1 entry or fewer.
- full, out, 1: FIFO holds DEPTH entries.
- almost_full, out, 1: FIFO holds DEPTH-1 entries or more.
- prog_full, out, 1: occupancy is at or above the threshold.
- rd_data_count, out, ADDR_WIDTH+1: current occupancy.
- wr_data_count, out, ADDR_WIDTH+1: current occupancy (same value as rd_data_count).

Behaviour:
- State: write pointer wptr, read pointer rptr (ADDR_WIDTH bits each, natural wrap at DEPTH), and occupancy register cnt (ADDR_WIDTH+1 bits, range 0..DEPTH).
- Reset (rst_n low, asynchronous):
  - wptr = rptr = cnt = 0.
  - Outputs: empty = 1, almost_empty = 1, full = 0, almost_full = 0, prog_full = 0, both counts = 0, dout = 0.
  - Memory contents are not cleared.
- Write acceptance: we = wr_en & ~full, using the flag value before the edge.
  - When accepted, mem[wptr] <= din and wptr increments.
  - A write while full is dropped silently and nothing changes.
- Read acceptance: re = rd_en & ~empty, using the flag value before the edge.
  - When accepted, rptr increments.
  - A read while empty is ignored.
- Count update, per edge:
  - we only: cnt+1.
  - re only: cnt-1.
  - both: unchanged.
  - neither: unchanged.
- Simultaneous read and write:
  - When empty, only the write takes effect.
  - When full, only the read takes effect.
  - Otherwise both take effect.
- FWFT read path:
  - dout = mem[rptr] combinationally whenever cnt != 0, and 0 when empty.
  - A word written at edge N is visible on dout, with empty = 0, right after edge N. Write-to-dout latency is 1 cycle.
  - After an accepted read, dout shows the next entry immediately after the edge.
- Flags are combinational decodes of cnt only; there is no direct din-to-flag path.
  - empty = (cnt == 0).
  - almost_empty = (cnt <= 1).
  - full = (cnt == DEPTH).
  - almost_full = (cnt >= DEPTH-1).
  - prog_full = (prog_full_thresh != 0) && (cnt >= prog_full_thresh).
- rd_data_count = wr_data_count = cnt.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Data order is preserved across the wrap.
- Reset asserted mid-operation discards all entries immediately. The first write after reset release lands at address 0.

Decomposition:
- Shared package ch_fifo_pkg holds:
  - constants CH_FIFO_DATA_WIDTH = 65 and CH_FIFO_ADDR_WIDTH = 9;
  - derived CH_FIFO_DEPTH;
  - bit index CH_LAST_BIT = 64.
- One sub-module, ch_fifo_ram: a simple dual-port array with a synchronous write port and an asynchronous read port. The top level holds the pointers, count and flag decode.

Test Plan:
- Reset, then idle → empty = 1, almost_empty = 1, full = 0, prog_full = 0, counts = 0, dout = 0.
- Write 0x1_0000_0000_0000_00AA once → on the next cycle dout = that value, empty = 0, almost_empty = 1, counts = 1. Then rd_en for one cycle → empty = 1, dout = 0.
- Fill 512 distinct words with thresh = 0x100:
  - prog_full rises when the count reaches 256;
  - almost_full rises at 511;
  - full rises at 512;
  - a 513th write is dropped and the count stays 512.
  - Drain all 512 → data comes out in order and the final empty = 1.
- Simultaneous rd_en and wr_en:
  - at cnt = 5, the count stays 5 and dout advances;
  - when empty, only the write lands (count becomes 1);
  - when full, only the read lands (count becomes 511).
- Wrap: 600 write/read pairs streamed at occupancy 3 → order preserved through pointer wrap and the count stays 3.
- Pulse rst_n low asynchronously with 10 entries stored → flags return to reset values immediately, without waiting for a clock edge. A subsequent write/read returns the new data, not stale data.
